// File: rtl/keypad_scan_encoder.sv
// Scans N_KEYS key lines, debounces the selected line and hands one code per press downstream.
// Optional auto-repeat while a key stays held: define KEY_AUTOREPEAT_EN.
module keypad_scan_encoder #(
  parameter int N_KEYS       = 12,
  parameter int CODE_W       = 4,
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CYC = 8,
  parameter int REPEAT_CYC   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  input  logic              scan_en,
  input  logic              key_ready,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held,
  output logic [CODE_W-1:0] scan_idx
);

  localparam int MAX_A = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int MAX_C = (MAX_A > REPEAT_CYC) ? MAX_A : REPEAT_CYC;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int PAD_W = 2 ** CODE_W;

  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEB_LIM  = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CODE_W-1:0] IDX_LAST = CODE_W'(N_KEYS - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_REPORT,
    ST_RELEASE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CODE_W-1:0] scan_idx_q;
  logic [CODE_W-1:0] scan_idx_d;
  logic [CODE_W-1:0] key_code_q;
  logic              key_valid_q;
  logic              key_held_q;
  logic [PAD_W-1:0]  key_pad;
  logic              sel;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
  logic [CNT_W-1:0] rep_q;
`endif

  // Pad to the full index range so an index beyond N_KEYS-1 can never select garbage.
  assign key_pad    = PAD_W'(key_in);
  assign sel        = key_pad[scan_idx_q];
  assign scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      div_q       <= '0;
      cnt_q       <= '0;
      scan_idx_q  <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (scan_en && sel) begin
            state_q    <= ST_DEBOUNCE;
            cnt_q      <= CNT_W'(1);
            key_held_q <= 1'b1;
          end else if (scan_en) begin
            if (div_q >= DIV_LAST) begin
              div_q      <= '0;
              scan_idx_q <= scan_idx_d;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!sel) begin
            state_q    <= ST_SCAN;
            scan_idx_q <= scan_idx_d;
            div_q      <= '0;
            key_held_q <= 1'b0;
          end else if (cnt_q >= DEB_LIM) begin
            state_q     <= ST_REPORT;
            key_code_q  <= scan_idx_q;
            key_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_REPORT: begin
          if (key_valid_q && key_ready) begin
            state_q     <= ST_RELEASE;
            key_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef KEY_AUTOREPEAT_EN
            rep_q       <= '0;
`endif
          end
        end
        ST_RELEASE: begin
          if (!sel) begin
`ifdef KEY_AUTOREPEAT_EN
            rep_q <= '0;
`endif
            if (cnt_q >= DEB_LAST) begin
              state_q    <= ST_SCAN;
              scan_idx_q <= scan_idx_d;
              div_q      <= '0;
              cnt_q      <= '0;
              key_held_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
`ifdef KEY_AUTOREPEAT_EN
            if (rep_q >= REP_LAST) begin
              state_q     <= ST_REPORT;
              key_valid_q <= 1'b1;
              rep_q       <= '0;
            end else begin
              rep_q <= rep_q + 1'b1;
            end
`endif
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign scan_idx  = scan_idx_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder: scan stepping, press, bounce, backpressure, reset, repeat.
module tb_keypad_scan_encoder;

  logic        clk;
  logic        rst;
  logic [11:0] key_in;
  logic        scan_en;
  logic        key_ready;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [3:0]  scan_idx;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  logic [3:0] last_code = '0;

  keypad_scan_encoder #(
    .N_KEYS(12), .CODE_W(4), .SCAN_DIV(4), .DEBOUNCE_CYC(8), .REPEAT_CYC(64)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .scan_en(scan_en), .key_ready(key_ready),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .scan_idx(scan_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_valid && key_ready) begin
      xfer_cnt++;
      last_code = key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idx(input logic [3:0] v, input string tag);
    int n = 0;
    while (scan_idx !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (scan_idx !== v) check(tag, 32'(scan_idx), 32'(v));
  endtask

  task automatic wait_valid(input int bound, input string tag);
    int n = 0;
    while (key_valid !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (key_valid !== 1'b1) check(tag, 32'(key_valid), 32'd1);
  endtask

  task automatic wait_held_low(input int bound, input string tag);
    int n = 0;
    while (key_held !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (key_held !== 1'b0) check(tag, 32'(key_held), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int x0;
    int lat;
    logic seen;
    logic prev_held;
    int exp_rep;

    rst = 1'b1; key_in = '0; scan_en = 1'b1; key_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_idx", 32'(scan_idx), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    rst = 1'b0;

    // idle scan: index steps every 4 clocks, wraps 11 -> 0
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (key_valid !== 1'b0) check("idle_valid", 32'(key_valid), 32'd0);
      if (c % 4 == 0) check("idle_idx", 32'(scan_idx), 32'((c / 4) % 12));
    end
    check("idle_held", 32'(key_held), 32'd0);

    // clean press of '*' with latency measured from index arrival
    x0 = xfer_cnt;
    wait_idx(4'd5, "wait_idx5");
    key_in[10] = 1'b1;
    wait_idx(4'd10, "wait_idx10");
    lat = 0;
    while (key_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("press_latency", 32'(lat), 32'd9);
    check("press_code", 32'(key_code), 32'd10);
    check("press_held", 32'(key_held), 32'd1);
    @(negedge clk);
    check("press_pulse", 32'(key_valid), 32'd0);
    check("press_xfer", 32'(xfer_cnt - x0), 32'd1);
    repeat (5) @(negedge clk);
    key_in[10] = 1'b0;
    repeat (7) @(negedge clk);
    check("release_held_hi", 32'(key_held), 32'd1);
    @(negedge clk);
    check("release_held_lo", 32'(key_held), 32'd0);
    check("release_idx", 32'(scan_idx), 32'd11);
    check("press_xfer_total", 32'(xfer_cnt - x0), 32'd1);

    // bouncing key 3: 5 high / 1 low never debounces
    x0 = xfer_cnt;
    seen = 1'b0;
    prev_held = key_held;
    for (int c = 0; c < 150; c++) begin
      key_in[3] = ((c % 6) < 5);
      @(negedge clk);
      if (key_held) seen = 1'b1;
      if (prev_held && !key_held) check("bounce_adv", 32'(scan_idx), 32'd4);
      prev_held = key_held;
    end
    check("bounce_engaged", 32'(seen), 32'd1);
    check("bounce_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    key_in[3] = 1'b1;
    wait_valid(100, "bounce_final_timeout");
    check("bounce_code", 32'(key_code), 32'd3);
    @(negedge clk);
    key_in[3] = 1'b0;
    wait_held_low(20, "bounce_release_timeout");
    check("bounce_xfer", 32'(xfer_cnt - x0), 32'd1);

    // backpressure on '#', released while waiting
    key_ready = 1'b0;
    key_in[11] = 1'b1;
    x0 = xfer_cnt;
    wait_valid(100, "bp_timeout");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 10) key_in[11] = 1'b0;
      check("bp_valid", 32'(key_valid), 32'd1);
      check("bp_code", 32'(key_code), 32'd11);
    end
    check("bp_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    key_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_clr", 32'(key_valid), 32'd0);
    check("bp_xfer", 32'(xfer_cnt - x0), 32'd1);
    wait_held_low(20, "bp_release_timeout");
    check("bp_wrap_idx", 32'(scan_idx), 32'd0);
    repeat (20) @(negedge clk);
    check("bp_xfer_total", 32'(xfer_cnt - x0), 32'd1);

    // asynchronous reset while a report is pending
    key_ready = 1'b0;
    key_in[5] = 1'b1;
    wait_valid(100, "arst_timeout");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(key_valid), 32'd0);
    check("arst_held", 32'(key_held), 32'd0);
    check("arst_idx", 32'(scan_idx), 32'd0);
    key_in = '0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    check("arst_no_report", 32'(seen), 32'd0);
    key_ready = 1'b1;

    // key 0 held 300 clocks
`ifdef KEY_AUTOREPEAT_EN
    exp_rep = 5;
`else
    exp_rep = 1;
`endif
    wait_idx(4'd11, "rep_wait11");
    wait_idx(4'd0, "rep_wait0");
    x0 = xfer_cnt;
    key_in[0] = 1'b1;
    repeat (300) @(negedge clk);
    key_in[0] = 1'b0;
    wait_held_low(20, "rep_release_timeout");
    check("rep_count", 32'(xfer_cnt - x0), 32'(exp_rep));
    check("rep_code", 32'(last_code), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
